fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 24-bit processor: holds the program counter, drives the word address into the instruction ROM, and registers the returned instruction into the IF/ID pipeline register. Sits directly upstream of the instruction memory (ROM read is combinational) and feeds the decode stage. Handles stall, branch redirect, halt detection and a fetched-instruction counter.

## Interface
- WIDTH, 24: instruction and address width.
- AMOUNT, 256: ROM depth in words; valid addresses 0..AMOUNT-1.
- RESET_PC, 0: PC value after reset.
- HALT_INSTR, 24'hFFFFFF: encoding that stops fetching.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- stall  in  1  decode/hazard unit requests hold of PC and IF/ID.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  WIDTH  redirect word address.
- imem_addr  out  WIDTH  word address to ROM; equals PC combinationally.
- imem_rd  in  WIDTH  instruction word returned by ROM in the same cycle.
- instr_d  out  WIDTH  IF/ID instruction register.
- pc_d  out  WIDTH  IF/ID copy of the PC the instruction came from.
- valid_d  out  1  IF/ID contents are a real instruction.
- halted  out  1  fetch FSM in HALT.
- addr_err  out  1  sticky: a redirect target was >= AMOUNT.
- fetch_count  out  16  number of instructions loaded with valid_d=1, saturating at 16'hFFFF.

## Operation
- PC is a word index; sequential next PC = PC+1, wrapping AMOUNT-1 -> 0.
- FSM states RUN, HALT. Priority each edge: rst > branch_taken > stall > normal.
- rst: PC=RESET_PC, instr_d=0, pc_d=0, valid_d=0, state RUN, halted=0, addr_err=0, fetch_count=0.
- branch_taken (any state, overrides stall):
  - target < AMOUNT: PC=branch_target, valid_d=0 (squash wrong-path instruction), state RUN.
  - target >= AMOUNT: addr_err=1, PC unchanged, valid_d=0, state HALT.
- stall (no redirect): PC, instr_d, pc_d, valid_d, fetch_count all hold; state holds.
- RUN, normal: instr_d=imem_rd, pc_d=PC, valid_d=1, fetch_count+1 (saturating).
  - imem_rd != HALT_INSTR: PC = next PC.
  - imem_rd == HALT_INSTR: halt instruction is still loaded (valid_d=1, counted), PC holds, state -> HALT.
- HALT, normal: PC holds, valid_d=0, instr_d/pc_d hold, fetch_count holds. Only a legal redirect or rst leaves HALT.
- halted is the registered FSM state; addr_err clears only on rst.

## Timing
- Instruction at address P appears on instr_d/pc_d one cycle after PC=P is driven on imem_addr.
- Redirect: branch_taken asserted in cycle N -> imem_addr=branch_target in N+1, its instruction on instr_d with valid_d=1 in N+2; valid_d=0 in N+1.
- Halt: HALT_INSTR on imem_rd in cycle N (RUN, no stall/redirect) -> cycle N+1 valid_d=1 with HALT_INSTR, halted=1; N+2 onward valid_d=0.
- Stall asserted in cycle N -> outputs in N+1 equal those of N; release resumes with no lost or duplicated instruction.
- Simultaneous branch_taken and stall: redirect wins, valid_d=0 next cycle.
- Simultaneous branch_taken and HALT_INSTR on imem_rd: redirect wins, halt instruction discarded, no HALT entry.
- rst asserted mid-operation overrides everything on that edge; first post-reset fetch uses RESET_PC.
- fetch_count increments exactly on edges where valid_d is written to 1.

## Test plan
- Reset then run with ROM words 0..4 = 24'h000001..24'h000005: instr_d follows 1,2,3,4,5 on consecutive cycles, pc_d 0..4, valid_d=1, fetch_count=5 after five cycles.
- Stall for 3 cycles while PC=2: imem_addr stays 2, instr_d/pc_d/valid_d frozen, fetch_count frozen; after release instr_d=word 2 then word 3, no duplicate.
- branch_taken with target 24'h000040 at PC=5: next cycle valid_d=0, imem_addr=0x40; following cycle pc_d=0x40, valid_d=1.
- ROM word 3 = 24'hFFFFFF: instr_d=24'hFFFFFF with valid_d=1 and halted=1, then valid_d=0 and imem_addr stuck at 3; branch_taken to 0 restores halted=0 and fetch from 0.
- Branch target 24'h000100 (AMOUNT=256): addr_err=1, halted=1, PC unchanged; rst clears addr_err, halted, fetch_count and sets imem_addr=RESET_PC.
- Sequential run from PC=255: next imem_addr=0; branch_taken plus stall together -> redirect taken, valid_d=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, ROM address drive and IF/ID register.
// Handles stall, branch redirect (with range check), halt detection and a saturating fetch counter.
module fetch_stage #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned AMOUNT     = 256,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] HALT_INSTR = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rd,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic             valid_d,
  output logic             halted,
  output logic             addr_err,
  output logic [15:0]      fetch_count
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  // One extra bit so the range check stays correct even when AMOUNT == 2**WIDTH.
  localparam logic [WIDTH:0]   AMOUNT_W = (WIDTH+1)'(AMOUNT);
  localparam logic [WIDTH-1:0] LAST_PC  = WIDTH'(AMOUNT - 1);

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next_seq;
  logic             target_ok;
  logic             is_halt_instr;
  logic [15:0]      count_inc;

  assign imem_addr     = pc;
  assign halted        = (state == S_HALT);
  assign pc_next_seq   = (pc == LAST_PC) ? '0 : pc + 1'b1;
  assign target_ok     = ({1'b0, branch_target} < AMOUNT_W);
  assign is_halt_instr = (imem_rd == HALT_INSTR);
  assign count_inc     = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;

  // Priority on every edge: rst, then redirect, then stall, then normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      instr_d     <= '0;
      pc_d        <= '0;
      valid_d     <= 1'b0;
      addr_err    <= 1'b0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      // The instruction fetched this cycle is on the wrong path either way.
      valid_d <= 1'b0;
      if (target_ok) begin
        pc    <= branch_target;
        state <= S_RUN;
      end else begin
        addr_err <= 1'b1;
        state    <= S_HALT;
      end
    end else if (!stall) begin
      case (state)
        S_RUN: begin
          instr_d     <= imem_rd;
          pc_d        <= pc;
          valid_d     <= 1'b1;
          fetch_count <= count_inc;
          if (is_halt_instr) begin
            state <= S_HALT;
          end else begin
            pc <= pc_next_seq;
          end
        end
        S_HALT: begin
          valid_d <= 1'b0;
        end
        default: begin
          state   <= S_HALT;
          valid_d <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a ROM array drives imem_rd combinationally,
// outputs are checked 1 time unit after each rising edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [23:0] branch_target;
  logic [23:0] imem_addr;
  logic [23:0] imem_rd;
  logic [23:0] instr_d;
  logic [23:0] pc_d;
  logic        valid_d;
  logic        halted;
  logic        addr_err;
  logic [15:0] fetch_count;

  logic [23:0] rom [0:255];
  int vectors;
  int miscompares;

  fetch_stage #(
    .WIDTH(24), .AMOUNT(256), .RESET_PC(24'h000000), .HALT_INSTR(24'hFFFFFF)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d), .halted(halted),
    .addr_err(addr_err), .fetch_count(fetch_count)
  );

  assign imem_rd = (imem_addr < 24'd256) ? rom[imem_addr[7:0]] : 24'h000000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the main pipeline outputs in one call.
  task automatic chk_out(input string tag, input logic [23:0] addr, input logic [23:0] instr,
                         input logic [23:0] pcd, input logic valid, input logic [15:0] cnt);
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".instr_d"}, instr_d, instr);
    chk({tag, ".pc_d"}, pc_d, pcd);
    chk({tag, ".valid_d"}, {23'd0, valid_d}, {23'd0, valid});
    chk({tag, ".fetch_count"}, {8'd0, fetch_count}, {8'd0, cnt});
  endtask

  task automatic chk_flags(input string tag, input logic h, input logic e);
    chk({tag, ".halted"}, {23'd0, halted}, {23'd0, h});
    chk({tag, ".addr_err"}, {23'd0, addr_err}, {23'd0, e});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) rom[i] = 24'(i + 1);
    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 24'h000000;

    // Reset state
    step();
    chk_out("reset", 24'h0, 24'h0, 24'h0, 1'b0, 16'd0);
    chk_flags("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // Sequential fetch of words 0 and 1
    step();
    chk_out("seq0", 24'h1, 24'h1, 24'h0, 1'b1, 16'd1);
    step();
    chk_out("seq1", 24'h2, 24'h2, 24'h1, 1'b1, 16'd2);

    // Stall three cycles with PC=2
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("stall%0d", k), 24'h2, 24'h2, 24'h1, 1'b1, 16'd2);
    end
    stall = 1'b0;
    step();
    chk_out("resume2", 24'h3, 24'h3, 24'h2, 1'b1, 16'd3);
    step();
    chk_out("resume3", 24'h4, 24'h4, 24'h3, 1'b1, 16'd4);
    step();
    chk_out("resume4", 24'h5, 24'h5, 24'h4, 1'b1, 16'd5);

    // Branch to 0x40 from PC=5
    branch_taken = 1'b1;
    branch_target = 24'h000040;
    step();
    chk_out("br40", 24'h40, 24'h5, 24'h4, 1'b0, 16'd5);
    branch_taken = 1'b0;
    step();
    chk_out("br40_fetch", 24'h41, 24'h41, 24'h40, 1'b1, 16'd6);

    // Halt instruction at word 3
    rom[3] = 24'hFFFFFF;
    branch_taken = 1'b1;
    branch_target = 24'h000000;
    step();
    chk_out("br0", 24'h0, 24'h41, 24'h40, 1'b0, 16'd6);
    branch_taken = 1'b0;
    step();
    chk_out("h_w0", 24'h1, 24'h1, 24'h0, 1'b1, 16'd7);
    step();
    chk_out("h_w1", 24'h2, 24'h2, 24'h1, 1'b1, 16'd8);
    step();
    chk_out("h_w2", 24'h3, 24'h3, 24'h2, 1'b1, 16'd9);
    step();
    chk_out("h_load", 24'h3, 24'hFFFFFF, 24'h3, 1'b1, 16'd10);
    chk_flags("h_load", 1'b1, 1'b0);
    step();
    chk_out("h_idle0", 24'h3, 24'hFFFFFF, 24'h3, 1'b0, 16'd10);
    step();
    chk_out("h_idle1", 24'h3, 24'hFFFFFF, 24'h3, 1'b0, 16'd10);
    chk_flags("h_idle1", 1'b1, 1'b0);
    rom[3] = 24'h000004;
    branch_taken = 1'b1;
    branch_target = 24'h000000;
    step();
    chk_out("h_exit", 24'h0, 24'hFFFFFF, 24'h3, 1'b0, 16'd10);
    chk_flags("h_exit", 1'b0, 1'b0);
    branch_taken = 1'b0;
    step();
    chk_out("h_refetch", 24'h1, 24'h1, 24'h0, 1'b1, 16'd11);

    // Redirect coinciding with a halt word on imem_rd: redirect wins
    rom[2] = 24'hFFFFFF;
    step();
    chk_out("bh_pre", 24'h2, 24'h2, 24'h1, 1'b1, 16'd12);
    branch_taken = 1'b1;
    branch_target = 24'h000010;
    step();
    chk_out("bh_br", 24'h10, 24'h2, 24'h1, 1'b0, 16'd12);
    chk_flags("bh_br", 1'b0, 1'b0);
    branch_taken = 1'b0;
    rom[2] = 24'h000003;
    step();
    chk_out("bh_fetch", 24'h11, 24'h11, 24'h10, 1'b1, 16'd13);

    // Out-of-range redirect
    branch_taken = 1'b1;
    branch_target = 24'h000100;
    step();
    chk_out("oor", 24'h11, 24'h11, 24'h10, 1'b0, 16'd13);
    chk_flags("oor", 1'b1, 1'b1);
    branch_taken = 1'b0;
    step();
    chk_out("oor_hold", 24'h11, 24'h11, 24'h10, 1'b0, 16'd13);
    chk_flags("oor_hold", 1'b1, 1'b1);

    // Reset mid-operation clears everything
    rst = 1'b1;
    step();
    chk_out("rst2", 24'h0, 24'h0, 24'h0, 1'b0, 16'd0);
    chk_flags("rst2", 1'b0, 1'b0);
    rst = 1'b0;

    // Wrap from PC=255
    branch_taken = 1'b1;
    branch_target = 24'h0000FF;
    step();
    chk_out("wr_br", 24'hFF, 24'h0, 24'h0, 1'b0, 16'd0);
    branch_taken = 1'b0;
    step();
    chk_out("wr_255", 24'h0, 24'h100, 24'hFF, 1'b1, 16'd1);
    step();
    chk_out("wr_0", 24'h1, 24'h1, 24'h0, 1'b1, 16'd2);

    // Branch together with stall: redirect wins
    branch_taken = 1'b1;
    branch_target = 24'h000020;
    stall = 1'b1;
    step();
    chk_out("bs_br", 24'h20, 24'h1, 24'h0, 1'b0, 16'd2);
    branch_taken = 1'b0;
    stall = 1'b0;
    step();
    chk_out("bs_fetch", 24'h21, 24'h21, 24'h20, 1'b1, 16'd3);
    chk_flags("bs_fetch", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
